// File: rtl/shift_rotate_pkg.sv
// Shared opcode encoding and op-class helpers for the shift/rotate pipeline.
package shift_rotate_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL  = 3'd0;
    localparam logic [OP_W-1:0] OP_SRL  = 3'd1;
    localparam logic [OP_W-1:0] OP_SRA  = 3'd2;
    localparam logic [OP_W-1:0] OP_ROL  = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd4;
    localparam logic [OP_W-1:0] OP_RCL  = 3'd5;
    localparam logic [OP_W-1:0] OP_RCR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    // Left ops are computed as right ops on a bit-reversed operand.
    function automatic logic is_left(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_ROL) || (op == OP_RCL);
    endfunction

    function automatic logic is_rot(input logic [OP_W-1:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    function automatic logic is_ring(input logic [OP_W-1:0] op);
        return (op == OP_RCL) || (op == OP_RCR);
    endfunction
endpackage

// File: rtl/shift_rotate_stage.sv
// One right-shifting barrel level by SHIFT bits; the bits entering from the top
// are the fill (shifts), the word itself (rotates) or the carry ring (RCL/RCR).
module shift_rotate_stage
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic             fill,
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    output logic [WIDTH-1:0] d_o,
    output logic             c_o
);
    logic             rot;
    logic             ring;
    logic [WIDTH-1:0] sh;

    assign rot  = is_rot(op);
    assign ring = is_ring(op);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i + SHIFT < WIDTH) begin : g_mid
            assign sh[i] = d[i+SHIFT];
        end else if (i + SHIFT == WIDTH) begin : g_edge
            assign sh[i] = rot ? d[0] : (ring ? c : fill);
        end else begin : g_top
            assign sh[i] = rot ? d[i+SHIFT-WIDTH] : (ring ? d[i+SHIFT-WIDTH-1] : fill);
        end
    end

    // In every mode the last bit shifted out of the data word becomes the carry.
    assign d_o = en ? sh : d;
    assign c_o = en ? d[SHIFT-1] : c;
endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined shifter/rotator with valid/ready flow control; the SHAMT_W barrel
// levels are spread evenly over PIPE_STAGES register slices.
module shift_rotate_pipe
    import shift_rotate_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int PIPE_STAGES = 2,
    localparam int SHAMT_W     = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [OP_W-1:0]    in_op,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_c,
    output logic               out_carry
);
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic               fill;
        logic [SHAMT_W-1:0] amt;
        logic               c;
        logic [WIDTH-1:0]   d;
    } slice_t;

    localparam logic [SHAMT_W-1:0] RING_N = SHAMT_W'(WIDTH + 1);

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    slice_t                 dec;
    slice_t [PIPE_STAGES-1:0] slice_d;
    slice_t [PIPE_STAGES-1:0] slice_q;
    slice_t                 last;
    logic [PIPE_STAGES-1:0] vld_pipe;
    logic [PIPE_STAGES-1:0] vprev;
    logic [PIPE_STAGES-1:0] take;
    logic                   unused_tail;

    always_comb begin
        dec      = '0;
        dec.op   = in_op;
        dec.d    = is_left(in_op) ? bitrev(in_a) : in_a;
        dec.fill = (in_op == OP_SRA) && in_a[WIDTH-1];
        dec.amt  = in_amt;
        if (in_op == OP_PASS)
            dec.amt = '0;
        else if (is_rot(in_op))
            dec.amt[SHAMT_W-1] = 1'b0;
        else if (is_ring(in_op) && (in_amt >= RING_N))
            dec.amt = in_amt - RING_N;
        // A rotate by a multiple of W still reports the result's edge bit, not cin.
        dec.c = (is_rot(in_op) && (in_amt != '0)) ? dec.d[WIDTH-1] : in_cin;
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
        localparam int G     = (k * PIPE_STAGES) / SHAMT_W;
        localparam bit FIRST = (k == 0) ? 1'b1 : (((k - 1) * PIPE_STAGES) / SHAMT_W != G);
        localparam bit LAST  = (k == SHAMT_W - 1) ? 1'b1 : (((k + 1) * PIPE_STAGES) / SHAMT_W != G);

        slice_t           din;
        slice_t           dout;
        logic [WIDTH-1:0] d_n;
        logic             c_n;

        if (k == 0) begin : g_src_dec
            assign din = dec;
        end else if (FIRST) begin : g_src_reg
            assign din = slice_q[G-1];
        end else begin : g_src_lvl
            assign din = g_lvl[k-1].dout;
        end

        shift_rotate_stage #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_stage (
            .en   (din.amt[k]),
            .op   (din.op),
            .fill (din.fill),
            .d    (din.d),
            .c    (din.c),
            .d_o  (d_n),
            .c_o  (c_n)
        );

        assign dout = '{op: din.op, fill: din.fill, amt: din.amt, c: c_n, d: d_n};

        if (LAST) begin : g_to_reg
            assign slice_d[G] = dout;
        end
    end

    // A slice can load when it, or any slice after it, has a hole, or the sink drains.
    for (genvar j = 0; j < PIPE_STAGES; j++) begin : g_flow
        assign take[j] = out_ready || !(&vld_pipe[PIPE_STAGES-1:j]);
        if (j == 0) begin : g_head
            assign vprev[j] = in_valid;
        end else begin : g_body
            assign vprev[j] = vld_pipe[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            slice_q  <= '0;
        end else begin
            for (int j = 0; j < PIPE_STAGES; j++) begin
                if (take[j]) begin
                    vld_pipe[j] <= vprev[j];
                    slice_q[j]  <= slice_d[j];
                end
            end
        end
    end

    assign last        = slice_q[PIPE_STAGES-1];
    assign in_ready    = take[0];
    assign out_valid   = vld_pipe[PIPE_STAGES-1];
    assign out_c       = is_left(last.op) ? bitrev(last.d) : last.d;
    assign out_carry   = last.c;
    assign unused_tail = ^{last.fill, last.amt};
endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe: directed corner cases, random stream with a
// back-pressure window, and reset with operations in flight.
module tb_shift_rotate_pipe;
    import shift_rotate_pkg::*;

    localparam int W  = 32;
    localparam int P  = 2;
    localparam int SW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [2:0]    in_op;
    logic [SW-1:0] in_amt;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_c;
    logic          out_carry;

    always #5 clk = ~clk;

    shift_rotate_pipe #(.WIDTH(W), .PIPE_STAGES(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_carry (out_carry)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int outs   = 0;

    logic [32:0] exp_q[$];
    int          acc_q[$];
    bit          stall_prev = 0;
    logic [32:0] held;
    bit          saw_full = 0;

    // Reference: {carry, result} straight from the operation definitions.
    function automatic logic [32:0] model(input int op, input logic [31:0] a, input int n, input logic cin);
        logic [31:0]        c;
        logic               cy;
        logic signed [31:0] sa;
        logic [32:0]        r;
        int                 m;
        if (n == 0 || op == 7) return {cin, a};
        c  = a;
        cy = cin;
        case (op)
            0: begin c = a << n; cy = (n <= 32) ? a[32-n] : 1'b0; end
            1: begin c = a >> n; cy = (n <= 32) ? a[n-1] : 1'b0; end
            2: begin
                sa = a;
                c  = (n >= 32) ? {32{a[31]}} : 32'(sa >>> n);
                cy = (n <= 32) ? a[n-1] : a[31];
            end
            3: begin m = n % 32; c = (a << m) | (a >> (32 - m)); cy = c[0]; end
            4: begin m = n % 32; c = (a >> m) | (a << (32 - m)); cy = c[31]; end
            5: begin r = {cin, a}; m = n % 33; r = (r << m) | (r >> (33 - m)); return r; end
            6: begin r = {cin, a}; m = n % 33; r = (r >> m) | (r << (33 - m)); return r; end
            default: ;
        endcase
        return {cy, c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic tick(output bit acc);
        logic [32:0] e;
        int          a;
        @(negedge clk);
        acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev)
                chk("hold", {out_valid, out_carry, out_c}, {1'b1, held});
            if (out_valid && out_ready) begin
                chk("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("result", {out_carry, out_c}, e);
                    chk("latency_min", (cyc - a) >= P, 1);
                end
                outs++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_carry, out_c};
            if (out_valid && !out_ready && !in_ready) saw_full = 1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(in_op), in_a, int'(in_amt), in_cin));
                acc_q.push_back(cyc);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input int n, input logic cin, input logic [31:0] ec, input logic ecy);
        bit acc;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_amt    = SW'(n);
        in_cin    = cin;
        out_ready = 1'b1;
        tick(acc);
        chk({tag, "_acc"}, acc, 1);
        in_valid = 1'b0;
        for (int i = 1; i < P; i++) begin
            chk({tag, "_early"}, out_valid, 0);
            tick(acc);
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_c"}, out_c, ec);
        chk({tag, "_carry"}, out_carry, ecy);
        tick(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          sent;
        int          t;
        int          outs0;
        int          edges[8];
        logic [2:0]  r_op;
        logic [31:0] r_a;
        int          r_n;
        logic        r_cin;

        edges     = '{0, 1, 31, 32, 33, 34, 62, 63};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_op     = '0;
        in_amt    = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        tick(acc);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_c", out_c, 0);
        chk("rst_out_carry", out_carry, 0);

        directed("sll1",    OP_SLL,  32'h8000_0001, 1,  1'b0, 32'h0000_0002, 1'b1);
        directed("sra40",   OP_SRA,  32'h8000_0000, 40, 1'b0, 32'hFFFF_FFFF, 1'b1);
        directed("srl40",   OP_SRL,  32'h8000_0000, 40, 1'b1, 32'h0000_0000, 1'b0);
        directed("rcl1",    OP_RCL,  32'h8000_0000, 1,  1'b0, 32'h0000_0000, 1'b1);
        directed("rcl33",   OP_RCL,  32'h8000_0000, 33, 1'b0, 32'h8000_0000, 1'b0);
        directed("ror32",   OP_ROR,  32'h0000_0001, 32, 1'b1, 32'h0000_0001, 1'b0);
        directed("rol0",    OP_ROL,  32'h0000_1234, 0,  1'b1, 32'h0000_1234, 1'b1);
        directed("pass",    OP_PASS, 32'hDEAD_BEEF, 17, 1'b1, 32'hDEAD_BEEF, 1'b1);
        directed("rcr1",    OP_RCR,  32'h0000_0001, 1,  1'b0, 32'h0000_0000, 1'b1);
        directed("sll32",   OP_SLL,  32'h0000_0001, 32, 1'b0, 32'h0000_0000, 1'b1);
        directed("srl32",   OP_SRL,  32'h8000_0000, 32, 1'b0, 32'h0000_0000, 1'b1);
        directed("rol1",    OP_ROL,  32'h8000_0000, 1,  1'b0, 32'h0000_0001, 1'b1);

        // Random stream, sink stalled for cycles 5..9 of this phase.
        outs0 = outs;
        sent  = 0;
        t     = 0;
        r_op  = 3'($urandom_range(0, 7));
        r_a   = $urandom;
        r_n   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 7)] : int'($urandom_range(0, 63));
        r_cin = 1'($urandom_range(0, 1));
        while (sent < 100 && t < 400) begin
            out_ready = !(t >= 5 && t <= 9);
            in_valid  = 1'b1;
            in_op     = r_op;
            in_a      = r_a;
            in_amt    = SW'(r_n);
            in_cin    = r_cin;
            tick(acc);
            if (acc) begin
                sent++;
                r_op  = 3'($urandom_range(0, 7));
                r_a   = $urandom;
                r_n   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 7)] : int'($urandom_range(0, 63));
                r_cin = 1'($urandom_range(0, 1));
            end
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(acc);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_sent", sent, 100);
        chk("rand_outs", outs - outs0, 100);
        chk("rand_full_stall", saw_full, 1);

        // Reset with two ops in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_SRL;
        in_a      = 32'hFFFF_0000;
        in_amt    = SW'(4);
        tick(acc);
        chk("inflight_acc0", acc, 1);
        tick(acc);
        chk("inflight_acc1", acc, 1);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick(acc);
        rst       = 1'b0;
        out_ready = 1'b1;
        outs0     = outs;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_c", out_c, 0);
        for (int i = 0; i < 4; i++) begin
            tick(acc);
            chk("dropped_no_valid", out_valid, 0);
        end
        chk("dropped_no_outs", outs - outs0, 0);
        directed("post_rst", OP_SRA, 32'h8000_00F0, 4, 1'b0, 32'hF800_000F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
